// File: rtl/video_timing_gen.sv
// Programmable raster timing generator: position counters, syncs, display enable
// and line/frame markers, with a shadowed configuration applied at frame wrap.
module video_timing_gen #(
    parameter int          CW            = 12,
    parameter int unsigned H_DISPLAY_DEF = 640,
    parameter int unsigned H_FRONT_DEF   = 16,
    parameter int unsigned H_SYNC_DEF    = 96,
    parameter int unsigned H_BACK_DEF    = 48,
    parameter int unsigned V_DISPLAY_DEF = 480,
    parameter int unsigned V_FRONT_DEF   = 10,
    parameter int unsigned V_SYNC_DEF    = 2,
    parameter int unsigned V_BACK_DEF    = 33,
    parameter bit          HS_POL_DEF    = 1'b0,
    parameter bit          VS_POL_DEF    = 1'b0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_en,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [CW-1:0] cfg_h_display,
    input  logic [CW-1:0] cfg_h_front,
    input  logic [CW-1:0] cfg_h_sync,
    input  logic [CW-1:0] cfg_h_back,
    input  logic [CW-1:0] cfg_v_display,
    input  logic [CW-1:0] cfg_v_front,
    input  logic [CW-1:0] cfg_v_sync,
    input  logic [CW-1:0] cfg_v_back,
    input  logic          cfg_hs_pol,
    input  logic          cfg_vs_pol,
    output logic          cfg_err,
    output logic [CW-1:0] hpos,
    output logic [CW-1:0] vpos,
    output logic          hsync,
    output logic          vsync,
    output logic          display_on,
    output logic          line_start,
    output logic          frame_start,
    output logic [15:0]   frame_count
);

    typedef struct packed {
        logic [CW-1:0] h_display;
        logic [CW-1:0] h_front;
        logic [CW-1:0] h_sync;
        logic [CW-1:0] h_back;
        logic [CW-1:0] v_display;
        logic [CW-1:0] v_front;
        logic [CW-1:0] v_sync;
        logic [CW-1:0] v_back;
        logic          hs_pol;
        logic          vs_pol;
    } timing_cfg_t;

    localparam timing_cfg_t CFG_DEF = '{
        h_display: CW'(H_DISPLAY_DEF), h_front: CW'(H_FRONT_DEF),
        h_sync:    CW'(H_SYNC_DEF),    h_back:  CW'(H_BACK_DEF),
        v_display: CW'(V_DISPLAY_DEF), v_front: CW'(V_FRONT_DEF),
        v_sync:    CW'(V_SYNC_DEF),    v_back:  CW'(V_BACK_DEF),
        hs_pol:    HS_POL_DEF,         vs_pol:  VS_POL_DEF
    };

    localparam logic [CW:0]   ONE_W     = (CW+1)'(1);
    localparam logic [CW+1:0] TOTAL_MAX = {2'b01, {CW{1'b0}}};

    // Validation sums use two guard bits so four maximal fields cannot alias
    // back under the 2^CW limit.
    function automatic logic [CW+1:0] sum4_wide(input logic [CW-1:0] a, b, c, d);
        return {2'b00, a} + {2'b00, b} + {2'b00, c} + {2'b00, d};
    endfunction

    function automatic logic [CW:0] sum2(input logic [CW-1:0] a, b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic [CW:0] sum4(input logic [CW-1:0] a, b, c, d);
        return sum2(a, b) + sum2(c, d);
    endfunction

    function automatic logic in_span(input logic [CW-1:0] pos, input logic [CW:0] start,
                                     input logic [CW-1:0] width);
        return ({1'b0, pos} >= start) && ({1'b0, pos} < start + {1'b0, width});
    endfunction

    timing_cfg_t act_cfg, pend_cfg, offered, next_cfg;
    logic        pend_full;
    logic        xfer, offer_bad, apply;
    logic [CW:0] h_total, v_total;
    logic        h_last, v_last, frame_wrap;
    logic [CW-1:0] hpos_nx, vpos_nx;
    logic        hs_in_nx, vs_in_nx, de_nx;

    always_comb begin
        offered.h_display = cfg_h_display;
        offered.h_front   = cfg_h_front;
        offered.h_sync    = cfg_h_sync;
        offered.h_back    = cfg_h_back;
        offered.v_display = cfg_v_display;
        offered.v_front   = cfg_v_front;
        offered.v_sync    = cfg_v_sync;
        offered.v_back    = cfg_v_back;
        offered.hs_pol    = cfg_hs_pol;
        offered.vs_pol    = cfg_vs_pol;
    end

    assign cfg_ready = ~pend_full;
    assign xfer      = cfg_valid && cfg_ready;

    always_comb begin
        offer_bad = (offered.h_display == '0) || (offered.h_sync == '0) ||
                    (offered.v_display == '0) || (offered.v_sync == '0);
        if (sum4_wide(offered.h_display, offered.h_front, offered.h_sync, offered.h_back) > TOTAL_MAX)
            offer_bad = 1'b1;
        if (sum4_wide(offered.v_display, offered.v_front, offered.v_sync, offered.v_back) > TOTAL_MAX)
            offer_bad = 1'b1;
    end

    assign h_total = sum4(act_cfg.h_display, act_cfg.h_front, act_cfg.h_sync, act_cfg.h_back);
    assign v_total = sum4(act_cfg.v_display, act_cfg.v_front, act_cfg.v_sync, act_cfg.v_back);

    // Comparing with >= keeps the counters bounded even from an unexpected state.
    assign h_last     = ({1'b0, hpos} >= h_total - ONE_W);
    assign v_last     = ({1'b0, vpos} >= v_total - ONE_W);
    assign frame_wrap = pix_en && h_last && v_last;
    assign apply      = frame_wrap && pend_full;
    assign next_cfg   = apply ? pend_cfg : act_cfg;

    always_comb begin
        hpos_nx = hpos;
        vpos_nx = vpos;
        if (pix_en) begin
            if (h_last) begin
                hpos_nx = '0;
                vpos_nx = v_last ? '0 : vpos + CW'(1);
            end else begin
                hpos_nx = hpos + CW'(1);
            end
        end
    end

    // Decoded from the next position and next configuration, so the registered
    // outputs line up with hpos/vpos, including across a configuration switch.
    always_comb begin
        hs_in_nx = in_span(hpos_nx, sum2(next_cfg.h_display, next_cfg.h_front), next_cfg.h_sync);
        vs_in_nx = in_span(vpos_nx, sum2(next_cfg.v_display, next_cfg.v_front), next_cfg.v_sync);
        de_nx    = (hpos_nx < next_cfg.h_display) && (vpos_nx < next_cfg.v_display);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            act_cfg     <= CFG_DEF;
            pend_cfg    <= '0;
            pend_full   <= 1'b0;
            cfg_err     <= 1'b0;
            hpos        <= '0;
            vpos        <= '0;
            frame_count <= '0;
            hsync       <= ~HS_POL_DEF;
            vsync       <= ~VS_POL_DEF;
            display_on  <= 1'b1;
            line_start  <= 1'b1;
            frame_start <= 1'b1;
        end else begin
            cfg_err <= xfer && offer_bad;
            act_cfg <= next_cfg;
            // xfer needs an empty slot and apply needs a full one: never both.
            if (xfer && !offer_bad) begin
                pend_cfg  <= offered;
                pend_full <= 1'b1;
            end else if (apply) begin
                pend_full <= 1'b0;
            end
            hpos        <= hpos_nx;
            vpos        <= vpos_nx;
            frame_count <= frame_count + 16'(frame_wrap);
            hsync       <= ~(hs_in_nx ^ next_cfg.hs_pol);
            vsync       <= ~(vs_in_nx ^ next_cfg.vs_pol);
            display_on  <= de_nx;
            line_start  <= (hpos_nx == '0);
            frame_start <= (hpos_nx == '0) && (vpos_nx == '0);
        end
    end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: randomized pixel strobes and configuration offers
// checked against a linear-pixel-index reference model.
module tb_video_timing_gen;

    localparam int CW = 12;
    localparam int VW = 2*CW + 23;
    localparam int HD = 640, HF = 16, HS = 96, HB = 48;
    localparam int VD = 4, VF = 1, VS = 2, VB = 1;
    localparam logic [VW-1:0] RST_VEC = {{(2*CW){1'b0}}, 5'b11111, 16'd0, 1'b1, 1'b0};

    typedef struct {
        int hd, hf, hs, hb, vd, vf, vs, vb;
        bit hp, vp;
    } cfg_t;

    logic clk = 1'b0;
    logic reset, pix_en, cfg_valid, cfg_ready, cfg_err;
    logic [CW-1:0] cfg_h_display, cfg_h_front, cfg_h_sync, cfg_h_back;
    logic [CW-1:0] cfg_v_display, cfg_v_front, cfg_v_sync, cfg_v_back;
    logic cfg_hs_pol, cfg_vs_pol;
    logic [CW-1:0] hpos, vpos;
    logic hsync, vsync, display_on, line_start, frame_start;
    logic [15:0] frame_count;
    logic [VW-1:0] dut_vec;

    int n_vec = 0, n_bad = 0;

    cfg_t m_a, m_p, cur;
    bit   m_full, m_err;
    int   m_pix, m_fc;

    video_timing_gen #(
        .CW(CW), .H_DISPLAY_DEF(HD), .H_FRONT_DEF(HF), .H_SYNC_DEF(HS), .H_BACK_DEF(HB),
        .V_DISPLAY_DEF(VD), .V_FRONT_DEF(VF), .V_SYNC_DEF(VS), .V_BACK_DEF(VB),
        .HS_POL_DEF(1'b0), .VS_POL_DEF(1'b0)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_h_display(cfg_h_display), .cfg_h_front(cfg_h_front), .cfg_h_sync(cfg_h_sync),
        .cfg_h_back(cfg_h_back), .cfg_v_display(cfg_v_display), .cfg_v_front(cfg_v_front),
        .cfg_v_sync(cfg_v_sync), .cfg_v_back(cfg_v_back), .cfg_hs_pol(cfg_hs_pol),
        .cfg_vs_pol(cfg_vs_pol), .cfg_err(cfg_err), .hpos(hpos), .vpos(vpos), .hsync(hsync),
        .vsync(vsync), .display_on(display_on), .line_start(line_start),
        .frame_start(frame_start), .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    assign dut_vec = {hpos, vpos, hsync, vsync, display_on, line_start, frame_start,
                      frame_count, cfg_ready, cfg_err};

    function automatic cfg_t mk(input int hd, hf, hs, hb, vd, vf, vs, vb, input bit hp, vp);
        cfg_t c;
        c.hd = hd; c.hf = hf; c.hs = hs; c.hb = hb;
        c.vd = vd; c.vf = vf; c.vs = vs; c.vb = vb;
        c.hp = hp; c.vp = vp;
        return c;
    endfunction

    function automatic int ht(input cfg_t c); return c.hd + c.hf + c.hs + c.hb; endfunction
    function automatic int vt(input cfg_t c); return c.vd + c.vf + c.vs + c.vb; endfunction

    function automatic bit bad(input cfg_t c);
        return c.hd == 0 || c.hs == 0 || c.vd == 0 || c.vs == 0 ||
               ht(c) > (1 << CW) || vt(c) > (1 << CW);
    endfunction

    function automatic cfg_t rnd_cfg();
        cfg_t c;
        c = mk($urandom_range(1, 4), $urandom_range(0, 2), $urandom_range(1, 3), $urandom_range(0, 2),
               $urandom_range(1, 4), $urandom_range(0, 2), $urandom_range(1, 3), $urandom_range(0, 2),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        case ($urandom_range(0, 7))
            0: c.hs = 0;
            1: c.vd = 0;
            default: ;
        endcase
        return c;
    endfunction

    // Position is a single pixel index within the frame; row/column fall out of it.
    function automatic logic [VW-1:0] model_vec();
        int h, v, t, hs0, vs0;
        bit hs, vs, de;
        t   = ht(m_a);
        h   = m_pix % t;
        v   = m_pix / t;
        hs0 = m_a.hd + m_a.hf;
        vs0 = m_a.vd + m_a.vf;
        hs  = (h >= hs0 && h < hs0 + m_a.hs) ? m_a.hp : !m_a.hp;
        vs  = (v >= vs0 && v < vs0 + m_a.vs) ? m_a.vp : !m_a.vp;
        de  = (h < m_a.hd) && (v < m_a.vd);
        return {CW'(h), CW'(v), hs, vs, de, (h == 0), (m_pix == 0), 16'(m_fc), !m_full, m_err};
    endfunction

    task automatic model_step();
        bit xfer, wrap, ok;
        if (reset) begin
            m_a = mk(HD, HF, HS, HB, VD, VF, VS, VB, 1'b0, 1'b0);
            m_full = 0; m_err = 0; m_pix = 0; m_fc = 0;
        end else begin
            xfer  = cfg_valid && !m_full;
            wrap  = pix_en && (m_pix == ht(m_a) * vt(m_a) - 1);
            ok    = !bad(cur);
            m_err = xfer && !ok;
            if (wrap && m_full) begin m_a = m_p; m_full = 0; end
            if (xfer && ok) begin m_p = cur; m_full = 1; end
            if (pix_en) begin
                if (wrap) begin m_pix = 0; m_fc++; end
                else m_pix++;
            end
        end
    endtask

    task automatic drive(input cfg_t c);
        cur = c;
        cfg_h_display = CW'(c.hd); cfg_h_front = CW'(c.hf);
        cfg_h_sync    = CW'(c.hs); cfg_h_back  = CW'(c.hb);
        cfg_v_display = CW'(c.vd); cfg_v_front = CW'(c.vf);
        cfg_v_sync    = CW'(c.vs); cfg_v_back  = CW'(c.vb);
        cfg_hs_pol = c.hp; cfg_vs_pol = c.vp;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1; cfg_valid = 1;
        drive(mk(4, 1, 2, 1, 3, 1, 1, 1, 1, 1));
        for (int i = 0; i < 3; i++) begin
            pix_en = 1'($urandom_range(0, 1));
            tick(); n_vec++;
            if (dut_vec !== model_vec()) begin
                n_bad++; $display("FAIL reset_model: got %h want %h", dut_vec, model_vec());
            end
        end
        n_vec++;
        if (dut_vec !== RST_VEC) begin
            n_bad++; $display("FAIL reset_values: got %h want %h", dut_vec, RST_VEC);
        end
        reset = 0; cfg_valid = 0; pix_en = 1;
    endtask

    task automatic test_defaults();
        for (int i = 0; i < 800 * 8 + 5; i++) begin
            tick(); n_vec++;
            if (dut_vec !== model_vec()) begin
                n_bad++; $display("FAIL defaults: pix=%0d got %h want %h", m_pix, dut_vec, model_vec());
            end
        end
        n_vec++;
        if ({frame_count, hpos, vpos} !== {16'd1, 12'd5, 12'd0}) begin
            n_bad++; $display("FAIL default_frame_done: got fc=%0d h=%0d v=%0d want fc=1 h=5 v=0",
                              frame_count, hpos, vpos);
        end
    endtask

    task automatic test_pix_en_gating();
        for (int i = 0; i < 1600; i++) begin
            pix_en = (i % 2 == 0);
            tick(); n_vec++;
            if (dut_vec !== model_vec()) begin
                n_bad++; $display("FAIL gating: i=%0d got %h want %h", i, dut_vec, model_vec());
            end
        end
        n_vec++;
        if ({hpos, vpos} !== {12'd5, 12'd1}) begin
            n_bad++; $display("FAIL gating_line_1600: got h=%0d v=%0d want h=5 v=1", hpos, vpos);
        end
        for (int i = 0; i < 300; i++) begin
            pix_en = 1'($urandom_range(0, 1));
            tick(); n_vec++;
            if (dut_vec !== model_vec()) begin
                n_bad++; $display("FAIL gating_rand: i=%0d got %h want %h", i, dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_reprogram();
        int g, fc0;
        pix_en = 1; g = 0;
        while (m_pix != 5 * 800 + 37 && g < 10000) begin
            tick(); g++; n_vec++;
            if (dut_vec !== model_vec()) begin
                n_bad++; $display("FAIL reprog_pre: got %h want %h", dut_vec, model_vec());
            end
        end
        drive(mk(4, 1, 2, 1, 3, 1, 1, 1, 1, 1)); cfg_valid = 1;
        tick(); cfg_valid = 0; n_vec++;
        if (cfg_ready !== 1'b0 || cfg_err !== 1'b0) begin
            n_bad++; $display("FAIL reprog_accept: got ready=%b err=%b want ready=0 err=0", cfg_ready, cfg_err);
        end
        fc0 = m_fc; g = 0;
        while (m_fc == fc0 && g < 10000) begin
            tick(); g++; n_vec++;
            if (dut_vec !== model_vec()) begin
                n_bad++; $display("FAIL reprog_old: got %h want %h", dut_vec, model_vec());
            end
        end
        n_vec++;
        if ({hpos, vpos, hsync, cfg_ready} !== {24'd0, 1'b0, 1'b1}) begin
            n_bad++; $display("FAIL reprog_switch: got h=%0d v=%0d hs=%b rdy=%b want 0 0 0 1",
                              hpos, vpos, hsync, cfg_ready);
        end
        for (int k = 1; k < 8; k++) begin
            tick(); n_vec++;
            if (hpos !== CW'(k) || hsync !== (k == 5 || k == 6)) begin
                n_bad++; $display("FAIL reprog_hsync: k=%0d got h=%0d hs=%b want h=%0d hs=%b",
                                  k, hpos, hsync, k, (k == 5 || k == 6));
            end
        end
        for (int i = 0; i < 96; i++) begin
            tick(); n_vec++;
            if (dut_vec !== model_vec()) begin
                n_bad++; $display("FAIL reprog_new: got %h want %h", dut_vec, model_vec());
            end
        end
    endtask

    task automatic test_back_to_back();
        int g, fc0;
        pix_en = 1; g = 0;
        while (m_pix != 1 && g < 200) begin
            tick(); g++; n_vec++;
            if (dut_vec !== model_vec()) begin
                n_bad++; $display("FAIL b2b_sync: got %h want %h", dut_vec, model_vec());
            end
        end
        drive(mk(3, 1, 1, 1, 2, 1, 1, 1, 0, 0)); cfg_valid = 1;
        tick(); n_vec++;
        if (dut_vec !== model_vec()) begin
            n_bad++; $display("FAIL b2b_first: got %h want %h", dut_vec, model_vec());
        end
        drive(mk(5, 1, 1, 1, 2, 1, 1, 1, 1, 0));
        for (int i = 0; i < 10; i++) begin
            tick(); n_vec++;
            if (dut_vec !== model_vec()) begin
                n_bad++; $display("FAIL b2b_backpressure: got %h want %h", dut_vec, model_vec());
            end
        end
        cfg_valid = 0; fc0 = m_fc; g = 0;
        while (m_fc == fc0 && g < 200) begin
            tick(); g++; n_vec++;
            if (dut_vec !== model_vec()) begin
                n_bad++; $display("FAIL b2b_drain: got %h want %h", dut_vec, model_vec());
            end
        end
        n_vec++;
        if (cfg_ready !== 1'b1 || frame_start !== 1'b1) begin
            n_bad++; $display("FAIL b2b_applied: got rdy=%b fs=%b want 1 1", cfg_ready, frame_start);
        end
        g = 0;
        while (m_pix != 29 && g < 200) begin
            tick(); g++; n_vec++;
            if (dut_vec !== model_vec()) begin
                n_bad++; $display("FAIL race_pre: got %h want %h", dut_vec, model_vec());
            end
        end
        drive(mk(2, 1, 1, 1, 2, 1, 1, 1, 0, 1)); cfg_valid = 1;
        tick(); cfg_valid = 0; n_vec++;
        if (frame_start !== 1'b1 || cfg_ready !== 1'b0) begin
            n_bad++; $display("FAIL race_capture: got fs=%b rdy=%b want fs=1 rdy=0", frame_start, cfg_ready);
        end
        for (int k = 1; k <= 30; k++) begin
            tick(); n_vec++;
            if (dut_vec !== model_vec()) begin
                n_bad++; $display("FAIL race_hold: k=%0d got %h want %h", k, dut_vec, model_vec());
            end
            if (k == 25 && frame_start !== 1'b0) begin
                n_vec++; n_bad++; $display("FAIL race_early: got fs=%b want 0 at pixel 25", frame_start);
            end
            if (k == 30 && (frame_start !== 1'b1 || cfg_ready !== 1'b1)) begin
                n_vec++; n_bad++; $display("FAIL race_apply: got fs=%b rdy=%b want 1 1", frame_start, cfg_ready);
            end
        end
        for (int k = 1; k <= 25; k++) begin
            tick(); n_vec++;
            if (dut_vec !== model_vec()) begin
                n_bad++; $display("FAIL race_new: k=%0d got %h want %h", k, dut_vec, model_vec());
            end
        end
        n_vec++;
        if (frame_start !== 1'b1) begin
            n_bad++; $display("FAIL race_new_total: got fs=%b want 1 after 25 pixels", frame_start);
        end
    endtask

    task automatic test_reject();
        cfg_t bads[3];
        bads[0] = mk(4, 1, 0, 1, 3, 1, 1, 1, 1, 1);
        bads[1] = mk(4000, 50, 50, 0, 3, 1, 1, 1, 0, 0);
        bads[2] = mk(4, 1, 1, 1, 0, 1, 1, 1, 0, 0);
        pix_en = 1;
        for (int b = 0; b < 3; b++) begin
            drive(bads[b]); cfg_valid = 1;
            tick(); cfg_valid = 0; n_vec++;
            if ({cfg_err, cfg_ready} !== 2'b11) begin
                n_bad++; $display("FAIL reject_pulse: b=%0d got err=%b rdy=%b want 1 1", b, cfg_err, cfg_ready);
            end
            tick(); n_vec++;
            if (cfg_err !== 1'b0) begin
                n_bad++; $display("FAIL reject_once: b=%0d got err=%b want 0", b, cfg_err);
            end
        end
        for (int i = 0; i < 30; i++) begin
            tick(); n_vec++;
            if (dut_vec !== model_vec()) begin
                n_bad++; $display("FAIL reject_keep: got %h want %h", dut_vec, model_vec());
            end
        end
        for (int i = 0; i < 600; i++) begin
            pix_en    = ($urandom_range(0, 3) != 0);
            cfg_valid = ($urandom_range(0, 5) == 0);
            drive(rnd_cfg());
            tick(); n_vec++;
            if (dut_vec !== model_vec()) begin
                n_bad++; $display("FAIL random: i=%0d got %h want %h", i, dut_vec, model_vec());
            end
        end
        cfg_valid = 0;
    endtask

    task automatic test_reset_pending();
        int g;
        logic exp_hs;
        pix_en = 1; g = 0;
        while (m_full && g < 1000) begin
            tick(); g++; n_vec++;
            if (dut_vec !== model_vec()) begin
                n_bad++; $display("FAIL rp_drain: got %h want %h", dut_vec, model_vec());
            end
        end
        drive(mk(4000, 32, 32, 32, 2, 1, 1, 1, 1, 1)); cfg_valid = 1;
        tick(); n_vec++;
        if ({cfg_ready, cfg_err} !== 2'b00) begin
            n_bad++; $display("FAIL accept_4096: got rdy=%b err=%b want 0 0", cfg_ready, cfg_err);
        end
        reset = 1;
        drive(mk(4, 1, 1, 1, 3, 1, 1, 1, 1, 1));
        tick(); tick();
        reset = 0; cfg_valid = 0; n_vec++;
        if (dut_vec !== RST_VEC) begin
            n_bad++; $display("FAIL rp_reset: got %h want %h", dut_vec, RST_VEC);
        end
        for (int i = 1; i <= 800; i++) begin
            tick(); n_vec++;
            if (dut_vec !== model_vec()) begin
                n_bad++; $display("FAIL rp_defaults: i=%0d got %h want %h", i, dut_vec, model_vec());
            end
            if (i == 655 || i == 656 || i == 751 || i == 752) begin
                exp_hs = !(i >= 656 && i <= 751);
                n_vec++;
                if (hpos !== CW'(i) || hsync !== exp_hs || cfg_ready !== 1'b1) begin
                    n_bad++; $display("FAIL rp_hsync: i=%0d got h=%0d hs=%b rdy=%b want h=%0d hs=%b rdy=1",
                                      i, hpos, hsync, cfg_ready, i, exp_hs);
                end
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        pix_en = 0; cfg_valid = 0; reset = 1;
        drive(mk(HD, HF, HS, HB, VD, VF, VS, VB, 1'b0, 1'b0));
        @(negedge clk);
        test_reset();
        test_defaults();
        test_pix_en_gating();
        test_reprogram();
        test_back_to_back();
        test_reject();
        test_reset_pending();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
